// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer.
//   state_e    : sequencer FSM states
//   CAUSE_*    : encodings reported on rst_cause
//   max_int    : constant helper used for counter sizing
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STAGGER = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after STAGES rising
// clock edges with the source reset high.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset source
//   rst_n_o : active-low reset, deassertion synchronous to clk_i
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic rst_n_o
);

  logic [STAGES-1:0] sync_q = '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all domains in reset for HOLD_CYCLES after the
// reset source clears, then releases them one at a time every
// STAGGER_CYCLES, and raises ready once the last domain is out of reset.
// A tick strobe every 2^DIV_LOG2 cycles runs while ready is high.
//   clock_in     : single clock
//   reset_ext    : asynchronous active-low reset
//   soft_rst_req : synchronous request to restart the sequence
//   resetn       : active-low reset per domain
//   ready        : all domains released
//   rst_cause    : 01 external/power-on, 10 soft
//   tick         : one-cycle clock-enable strobe
//
// state   | meaning
// HOLD    | all domains in reset, counting HOLD_CYCLES
// STAGGER | releasing domains 1..N-1, one every STAGGER_CYCLES
// RUN     | every domain released, ready high
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_DOMAINS      = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int DIV_LOG2       = 2
) (
  input  logic                 clock_in,
  input  logic                 reset_ext,
  input  logic                 soft_rst_req,
  output logic [N_DOMAINS-1:0] resetn,
  output logic                 ready,
  output logic [1:0]           rst_cause,
  output logic                 tick
);

  if (N_DOMAINS < 1 || N_DOMAINS > 8) begin : g_bad_domains
    $error("reset_sequencer: N_DOMAINS must be in 1..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be at least 1");
  end
  if (N_DOMAINS > 1 && STAGGER_CYCLES < 1) begin : g_bad_stagger
    $error("reset_sequencer: STAGGER_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be at least 2");
  end
  if (DIV_LOG2 < 0) begin : g_bad_div
    $error("reset_sequencer: DIV_LOG2 must not be negative");
  end

  // Sized so the largest terminal count fits; the counter is cleared on
  // every terminal count, so it never wraps.
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, STAGGER_CYCLES) + 1);
  localparam logic [CNT_W-1:0]     HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]     STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [N_DOMAINS-1:0] DOM_ONE   = N_DOMAINS'(1);

  logic rst_int_n;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk_i   (clock_in),
    .rst_n_i (reset_ext),
    .rst_n_o (rst_int_n)
  );

  state_e               state_q  = HOLD;
  state_e               state_d;
  logic [CNT_W-1:0]     cnt_q    = '0;
  logic [CNT_W-1:0]     cnt_d;
  logic [N_DOMAINS-1:0] resetn_q = '0;
  logic [N_DOMAINS-1:0] resetn_d;
  logic                 ready_q  = 1'b0;
  logic                 ready_d;
  logic [1:0]           cause_q  = CAUSE_EXT;
  logic [1:0]           cause_d;

  always_ff @(posedge clock_in or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      resetn_q <= '0;
      ready_q  <= 1'b0;
      cause_q  <= CAUSE_EXT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      resetn_q <= resetn_d;
      ready_q  <= ready_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    resetn_d = resetn_q;
    ready_d  = ready_q;
    cause_d  = cause_q;
    if (soft_rst_req) begin
      // A soft request restarts the sequence from any state.
      state_d  = HOLD;
      cnt_d    = '0;
      resetn_d = '0;
      ready_d  = 1'b0;
      cause_d  = CAUSE_SOFT;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            resetn_d[0] = 1'b1;
            cnt_d       = '0;
            if (N_DOMAINS == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = STAGGER;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STAGGER: begin
          if (cnt_q == STAG_LAST) begin
            cnt_d = '0;
            // Released bits form a contiguous run from bit 0, so shifting in
            // a one releases the next domain in index order.
            resetn_d = (resetn_q << 1) | DOM_ONE;
            if (resetn_d[N_DOMAINS-1]) begin
              ready_d = 1'b1;
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

  if (DIV_LOG2 > 0) begin : g_div
    logic [DIV_LOG2-1:0] div_q = '0;
    logic [DIV_LOG2-1:0] div_d;

    // Counting starts the edge after ready rises, so the counter is 0 in
    // the first ready cycle and the first tick lands 2^DIV_LOG2-1 later.
    always_comb begin
      div_d = '0;
      if (ready_q && ready_d) begin
        div_d = div_q + DIV_LOG2'(1);
      end
    end

    always_ff @(posedge clock_in or negedge rst_int_n) begin
      if (!rst_int_n) begin
        div_q <= '0;
      end else begin
        div_q <= div_d;
      end
    end

    assign tick = ready_q & (&div_q);
  end else begin : g_no_div
    assign tick = ready_q;
  end

  assign resetn    = resetn_q;
  assign ready     = ready_q;
  assign rst_cause = cause_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  N_DOMAINS       3    number of reset domains; legal range 1..8
  HOLD_CYCLES     16   cycles that all domains are held in reset after the reset source clears; minimum 1
  STAGGER_CYCLES  4    cycles between successive domain releases; minimum 1; ignored when N_DOMAINS=1
  SYNC_STAGES     2    flops in the reset_ext deassertion synchroniser; minimum 2
  DIV_LOG2        2    tick period is 2^DIV_LOG2 cycles; 0 makes tick equal ready
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clock_in      in   1          the single clock
  reset_ext     in   1          asynchronous, active-low reset
  soft_rst_req  in   1          synchronous request to re-run the reset sequence
  resetn        out  N_DOMAINS  active-low reset per domain
  ready         out  1          high when every domain is released
  rst_cause     out  2          01 = external/power-on reset, 10 = soft reset; 00 and 11 never driven
  tick          out  1          one-cycle clock-enable strobe
REQ-003 The block SHALL use one clock, clock_in; reset_ext SHALL be asynchronous and active-low.

Function
REQ-004 Assertion of reset_ext SHALL clear resetn, ready and tick immediately, with no clock edge required.
REQ-005 Deassertion of reset_ext SHALL reach the internal reset only after SYNC_STAGES rising edges of clock_in with reset_ext high.
REQ-006 The FSM SHALL have exactly three states: HOLD, STAGGER and RUN.
REQ-007 The FSM SHALL enter HOLD on reset, with the cycle counter at 0.
REQ-008 In HOLD, the counter SHALL increment every cycle; when it equals HOLD_CYCLES-1, the next edge SHALL:
  - set resetn[0]=1;
  - clear the counter;
  - move the FSM to STAGGER, or to RUN when N_DOMAINS=1.
REQ-009 In STAGGER, the block SHALL release resetn[k] exactly STAGGER_CYCLES edges after resetn[k-1], for k = 1..N_DOMAINS-1.
REQ-010 The edge that releases resetn[N_DOMAINS-1] SHALL also set ready=1 and move the FSM to RUN.
REQ-011 Released domains SHALL stay released until the next reset event; resetn bits SHALL rise only in ascending index order.
REQ-012 When soft_rst_req is sampled high at edge E, in any state, the block SHALL do the following at edge E:
  - resetn = 0 and ready = 0;
  - FSM to HOLD with the counter at 0;
  - rst_cause = 10.
  resetn[0] SHALL then rise at edge E+HOLD_CYCLES if no further request arrives.
REQ-013 If soft_rst_req is held high continuously, the counter SHALL restart every cycle and resetn SHALL stay all zero.
REQ-014 rst_cause SHALL hold its value until the next reset event.
REQ-015 If reset_ext is asserted in the same cycle that soft_rst_req is sampled high, reset_ext SHALL win and rst_cause SHALL be 01.
REQ-016 Tick divider behaviour:
  - it is a DIV_LOG2-bit counter, held at 0 while ready=0, and incrementing and wrapping while ready=1;
  - tick = ready AND (counter all ones), decoded combinationally from registers;
  - the first tick is in the cycle after edge R+2^DIV_LOG2-1, where R is the edge at which ready rises.
REQ-017 The cycle counter width SHALL be the clog2 of (max(HOLD_CYCLES, STAGGER_CYCLES)+1), and the counter SHALL never wrap.
REQ-018 Illegal parameter values SHALL cause an elaboration-time error.

Reset
REQ-019 The reset values SHALL be: resetn = 0, ready = 0, tick = 0, rst_cause = 01, FSM = HOLD, all counters = 0.
REQ-020 All registers SHALL also carry these values as power-up initial values, so that the block works before any reset_ext edge.
REQ-021 Every output SHALL be a register or a decode of registers; no output SHALL be combinational from an input, except the asynchronous clear by reset_ext.

Structure
REQ-022 A shared package SHALL hold:
  - the FSM state enum (HOLD, STAGGER, RUN);
  - the rst_cause codes CAUSE_EXT = 2'b01 and CAUSE_SOFT = 2'b10.
REQ-023 The block SHALL contain exactly one sub-module, reset_sync, which asserts asynchronously and deasserts synchronously; its depth parameter SHALL be SYNC_STAGES.

Verification
Unless noted, parameters are at their defaults and cycle numbers count edges after reset_ext rises.
REQ-024 Power-on: reset_ext low for 5 cycles, then high -> resetn[0] rises after edge 18, resetn[1] after 22, resetn[2] and ready after 26; rst_cause = 01.
REQ-025 Soft reset: a one-cycle soft_rst_req at edge E while in RUN -> resetn = 000 and ready = 0 after E; rst_cause = 10; resetn[0] rises at E+16, resetn[2] at E+24.
REQ-026 Mid-stagger external reset: reset_ext pulled low while resetn = 001 -> resetn = 000 with no clock edge; after release the full sequence repeats; rst_cause = 01.
REQ-027 Tick: with ready rising at edge R -> tick is high in the cycles after R+3, R+7, R+11 and low at every other cycle; tick = 0 during HOLD.
REQ-028 Held soft reset: soft_rst_req high for 40 cycles -> resetn stays 000 throughout; resetn[0] rises 16 edges after the last sampled request.
REQ-029 Single domain: N_DOMAINS = 1, DIV_LOG2 = 0 -> resetn[0] and ready rise together after edge 18; tick equals ready from then on.
